// File: rtl/vga_framebuffer_pkg.sv
// Shared geometry and FSM encoding for the framebuffer and the scan-out block.
// The scan-out timing logic takes its cell grid from these same constants.
package vga_pkg;
  localparam int H_CELLS = 20;
  localparam int V_CELLS = 15;
  localparam int DEPTH   = H_CELLS * V_CELLS;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    WAIT_VS = 2'd2
  } fb_state_t;
endpackage

// File: rtl/vga_framebuffer_if.sv
// CPU bus and video scan-out signals of the framebuffer, bundled as one interface.
// The master side drives requests; the slave side is the framebuffer itself.
interface vga_framebuffer_if;
  logic                         cpu_we;
  logic [vga_pkg::ADDR_W-1:0]   cpu_addr;
  logic [vga_pkg::DATA_W-1:0]   cpu_wdata;
  logic [vga_pkg::DATA_W-1:0]   cpu_rdata;
  logic                         swap_req;
  logic                         clear_req;
  logic                         swap_pending;
  logic                         swap_done;
  logic                         clear_busy;
  logic                         front_sel;
  logic                         vga_vs_n;
  logic [vga_pkg::ADDR_W-1:0]   vaddr;
  logic [vga_pkg::DATA_W-1:0]   vdata;

  modport master (
    output cpu_we, cpu_addr, cpu_wdata, swap_req, clear_req, vga_vs_n, vaddr,
    input  cpu_rdata, swap_pending, swap_done, clear_busy, front_sel, vdata
  );

  modport slave (
    input  cpu_we, cpu_addr, cpu_wdata, swap_req, clear_req, vga_vs_n, vaddr,
    output cpu_rdata, swap_pending, swap_done, clear_busy, front_sel, vdata
  );
endinterface

// File: rtl/vga_framebuffer_fb_bank.sv
// One cell bank: single write port, two registered read ports, read-first.
// Contents are never reset; the caller guarantees the write address is in range.
module fb_bank import vga_pkg::*; #(
  parameter int WORDS = DEPTH,
  parameter int AW    = ADDR_W,
  parameter int DW    = DATA_W
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [DW-1:0] o_rdata_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_b
);
  localparam logic [AW-1:0] WORDS_A = AW'(WORDS);

  logic [DW-1:0] r_mem [WORDS];
  logic [DW-1:0] r_rdata_a;
  logic [DW-1:0] r_rdata_b;

  // Non-blocking reads sample the pre-write word, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_raddr_a < WORDS_A) r_rdata_a <= r_mem[i_raddr_a];
    if (i_raddr_b < WORDS_A) r_rdata_b <= r_mem[i_raddr_b];
  end

  assign o_rdata_a = r_rdata_a;
  assign o_rdata_b = r_rdata_b;
endmodule

// File: rtl/vga_framebuffer.sv
// Double-buffered cell memory: CPU owns the back bank, scan-out reads the front bank,
// banks swap on a vsync falling edge and the back bank can be hardware-cleared.
module vga_framebuffer import vga_pkg::*; (
  input  logic               clk,
  input  logic               reset_n,
  vga_framebuffer_if.slave   bus
);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  fb_state_t         r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_front_sel;
  logic              r_swap_done;
  logic              r_vs_prev;
  logic              r_c_ok, r_v_ok;
  logic              r_c_bank, r_v_bank;

  logic                          w_vs_fall;
  logic                          w_cpu_ok, w_vid_ok;
  logic                          w_clearing;
  logic                          w_we;
  logic [ADDR_W-1:0]             w_waddr;
  logic [DATA_W-1:0]             w_wdata;
  logic [1:0][DATA_W-1:0]        w_rd_cpu;
  logic [1:0][DATA_W-1:0]        w_rd_vid;

  assign w_vs_fall  = r_vs_prev & ~bus.vga_vs_n;
  assign w_cpu_ok   = bus.cpu_addr < DEPTH_A;
  assign w_vid_ok   = bus.vaddr < DEPTH_A;
  assign w_clearing = (r_state == CLEAR);

  // The clear engine owns the back-bank write port; CPU writes are dropped meanwhile.
  assign w_we    = w_clearing | (bus.cpu_we & w_cpu_ok);
  assign w_waddr = w_clearing ? r_clr_cnt : bus.cpu_addr;
  assign w_wdata = w_clearing ? '0 : bus.cpu_wdata;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fb_bank u_bank (
      .clk       (clk),
      .i_we      (w_we & (r_front_sel != 1'(b))),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata),
      .i_raddr_a (bus.cpu_addr),
      .o_rdata_a (w_rd_cpu[b]),
      .i_raddr_b (bus.vaddr),
      .o_rdata_b (w_rd_vid[b])
    );
  end

  // Bank select and range flag travel with the read so a same-edge swap
  // still returns the word from the bank that was addressed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_c_ok   <= 1'b0;
      r_v_ok   <= 1'b0;
      r_c_bank <= 1'b0;
      r_v_bank <= 1'b0;
    end else begin
      r_c_ok   <= w_cpu_ok;
      r_v_ok   <= w_vid_ok;
      r_c_bank <= ~r_front_sel;
      r_v_bank <= r_front_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_clr_cnt   <= '0;
      r_front_sel <= 1'b0;
      r_swap_done <= 1'b0;
      r_vs_prev   <= 1'b1;
    end else begin
      r_vs_prev   <= bus.vga_vs_n;
      r_swap_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.clear_req) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
          end else if (bus.swap_req) begin
            r_state <= WAIT_VS;
          end
        end
        CLEAR: begin
          if (r_clr_cnt == LAST_A) r_state   <= IDLE;
          else                     r_clr_cnt <= r_clr_cnt + 1'b1;
        end
        WAIT_VS: begin
          if (w_vs_fall) begin
            r_front_sel <= ~r_front_sel;
            r_swap_done <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata    = r_c_ok ? w_rd_cpu[r_c_bank] : '0;
  assign bus.vdata        = r_v_ok ? w_rd_vid[r_v_bank] : '0;
  assign bus.swap_pending = (r_state == WAIT_VS);
  assign bus.clear_busy   = w_clearing;
  assign bus.swap_done    = r_swap_done;
  assign bus.front_sel    = r_front_sel;
endmodule

// File: tb/tb_vga_framebuffer.sv
// Self-checking bench: directed sequences, a vector table and random traffic,
// all compared against a cycle model of two word arrays plus swap/clear bookkeeping.
module tb_vga_framebuffer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vga_framebuffer_if bus();
  vga_framebuffer dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  logic        in_we = 0, in_swap = 0, in_clear = 0, in_vs = 1;
  logic [8:0]  in_addr = 0, in_vaddr = 0;
  logic [31:0] in_wdata = 0;
  assign bus.cpu_we    = in_we;
  assign bus.cpu_addr  = in_addr;
  assign bus.cpu_wdata = in_wdata;
  assign bus.swap_req  = in_swap;
  assign bus.clear_req = in_clear;
  assign bus.vga_vs_n  = in_vs;
  assign bus.vaddr     = in_vaddr;

  int checks = 0, errors = 0;

  // Reference model: bank contents (with known flags), displayed bank,
  // outstanding swap, remaining clear words, previous vsync level.
  logic [31:0] m_mem   [2][300];
  bit          m_known [2][300];
  bit          m_front = 0, m_pending = 0, m_vs_prev = 1;
  int          m_clear_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_front = 0; m_pending = 0; m_vs_prev = 1; m_clear_left = 0;
  endtask

  task automatic tick();
    int b, idx;
    bit clearing, vs_fall, rk, vk, ed;
    logic [31:0] er, ev;
    b = m_front ? 0 : 1;
    clearing = (m_clear_left > 0);
    if (in_addr < 300) begin rk = m_known[b][in_addr]; er = m_mem[b][in_addr]; end
    else begin rk = 1; er = 0; end
    if (in_vaddr < 300) begin vk = m_known[1-b][in_vaddr]; ev = m_mem[1-b][in_vaddr]; end
    else begin vk = 1; ev = 0; end
    vs_fall = m_vs_prev && !in_vs;
    ed = 0;
    if (clearing) begin
      idx = 300 - m_clear_left;
      m_mem[b][idx] = 0; m_known[b][idx] = 1;
      m_clear_left--;
    end else if (m_pending) begin
      if (vs_fall) begin m_front = !m_front; ed = 1; m_pending = 0; end
    end else if (in_clear) m_clear_left = 300;
    else if (in_swap) m_pending = 1;
    if (in_we && in_addr < 300 && !clearing) begin
      m_mem[b][in_addr] = in_wdata; m_known[b][in_addr] = 1;
    end
    m_vs_prev = in_vs;
    @(posedge clk); #1;
    if (rk) chk("cpu_rdata", bus.cpu_rdata, er);
    if (vk) chk("vdata", bus.vdata, ev);
    chk("swap_done", 32'(bus.swap_done), 32'(ed));
    chk("swap_pending", 32'(bus.swap_pending), 32'(m_pending));
    chk("clear_busy", 32'(bus.clear_busy), 32'(m_clear_left > 0));
    chk("front_sel", 32'(bus.front_sel), 32'(m_front));
  endtask

  task automatic wait_clear();
    int g = 0;
    while (bus.clear_busy && g < 400) begin tick(); g++; end
    chk("clear_timeout", 32'(bus.clear_busy), 32'd0);
  endtask

  typedef struct {
    bit          we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [8:0]  vaddr;
    logic [31:0] exp_rdata;
    logic [31:0] exp_vdata;
  } vec_t;
  vec_t tbl[12];

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt, b_clr;
    logic [31:0] exp;
    for (int b = 0; b < 2; b++) for (int a = 0; a < 300; a++) begin
      m_known[b][a] = 0; m_mem[b][a] = 0;
    end

    // Reset state
    #12;
    chk("rst_rdata", bus.cpu_rdata, 0);
    chk("rst_vdata", bus.vdata, 0);
    chk("rst_front", 32'(bus.front_sel), 0);
    chk("rst_pending", 32'(bus.swap_pending), 0);
    chk("rst_busy", 32'(bus.clear_busy), 0);
    chk("rst_done", 32'(bus.swap_done), 0);
    reset_n = 1;

    // Back-bank write/readback, front untouched
    in_we = 1; in_addr = 7; in_wdata = 32'hA5; tick();
    in_we = 0; in_vaddr = 7; tick();
    chk("t1_rdata", bus.cpu_rdata, 32'hA5);
    checks++;
    if (bus.vdata === 32'hA5) begin
      errors++; $display("FAIL t1_front_untouched: got %h expected not a5", bus.vdata);
    end

    // Swap waits for vsync fall
    in_swap = 1; tick(); in_swap = 0;
    for (int i = 0; i < 10; i++) begin tick(); chk("t2_pending", 32'(bus.swap_pending), 1); end
    in_vs = 0; tick();
    chk("t2_done", 32'(bus.swap_done), 1);
    chk("t2_front", 32'(bus.front_sel), 1);
    tick();
    chk("t2_vdata", bus.vdata, 32'hA5);
    in_vs = 1; tick();

    // Clear: 300 busy cycles, CPU writes dropped
    in_clear = 1; tick(); in_clear = 0;
    busy_cnt = 0;
    in_we = 1; in_addr = 5; in_wdata = 32'hDEADBEEF;
    while (bus.clear_busy && busy_cnt < 400) begin busy_cnt++; tick(); end
    in_we = 0;
    chk("t3_busy_cycles", busy_cnt, 300);
    foreach (tbl[i]) ;
    in_addr = 0;   tick(); chk("t3_rd0", bus.cpu_rdata, 0);
    in_addr = 150; tick(); chk("t3_rd150", bus.cpu_rdata, 0);
    in_addr = 299; tick(); chk("t3_rd299", bus.cpu_rdata, 0);
    in_addr = 5;   tick(); chk("t3_rd5", bus.cpu_rdata, 0);

    // Swap back and clear the other bank so both are fully known
    in_swap = 1; tick(); in_swap = 0; tick();
    in_vs = 0; tick(); in_vs = 1; tick();
    in_clear = 1; tick(); in_clear = 0; wait_clear();

    // swap_req coinciding with vsync fall is not taken
    in_swap = 1; in_vs = 0; tick(); in_swap = 0;
    chk("t4_front_hold", 32'(bus.front_sel), 0);
    chk("t4_pending", 32'(bus.swap_pending), 1);
    repeat (3) tick();
    chk("t4_no_toggle", 32'(bus.front_sel), 0);
    in_vs = 1; tick(); in_vs = 0; tick();
    chk("t4_done", 32'(bus.swap_done), 1);
    chk("t4_front", 32'(bus.front_sel), 1);
    in_vs = 1; tick();
    in_clear = 1; in_swap = 1; tick(); in_clear = 0; in_swap = 0;
    chk("t4_clr_wins_busy", 32'(bus.clear_busy), 1);
    chk("t4_clr_wins_pend", 32'(bus.swap_pending), 0);
    wait_clear();
    chk("t4_no_late_pend", 32'(bus.swap_pending), 0);

    // Vector table: both banks zero here
    tbl[0]  = '{1, 9'd7,   32'hA5,       9'd300, 32'h0,        32'h0};
    tbl[1]  = '{0, 9'd7,   32'h0,        9'd345, 32'hA5,       32'h0};
    tbl[2]  = '{1, 9'd299, 32'h12345678, 9'd299, 32'h0,        32'h0};
    tbl[3]  = '{0, 9'd299, 32'h0,        9'd0,   32'h12345678, 32'h0};
    tbl[4]  = '{1, 9'd511, 32'hFFFFFFFF, 9'd44,  32'h0,        32'h0};
    tbl[5]  = '{0, 9'd299, 32'h0,        9'd511, 32'h12345678, 32'h0};
    tbl[6]  = '{0, 9'd44,  32'h0,        9'd300, 32'h0,        32'h0};
    tbl[7]  = '{0, 9'd300, 32'h0,        9'd7,   32'h0,        32'h0};
    tbl[8]  = '{1, 9'd44,  32'hDEADBEEF, 9'd44,  32'h0,        32'h0};
    tbl[9]  = '{1, 9'd44,  32'hCAFEF00D, 9'd345, 32'hDEADBEEF, 32'h0};
    tbl[10] = '{0, 9'd44,  32'h0,        9'd299, 32'hCAFEF00D, 32'h0};
    tbl[11] = '{0, 9'd511, 32'h0,        9'd1,   32'h0,        32'h0};
    for (int i = 0; i < 12; i++) begin
      in_we = tbl[i].we; in_addr = tbl[i].addr; in_wdata = tbl[i].wdata; in_vaddr = tbl[i].vaddr;
      tick();
      chk($sformatf("tbl%0d_rdata", i), bus.cpu_rdata, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_vdata", i), bus.vdata, tbl[i].exp_vdata);
    end
    in_we = 0;

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      in_we    = $urandom_range(0, 1);
      in_addr  = ($urandom_range(0, 15) == 0) ? 9'($urandom_range(300, 511)) : 9'($urandom_range(0, 299));
      in_wdata = $urandom;
      in_vaddr = 9'($urandom_range(0, 345));
      in_swap  = ($urandom_range(0, 15) == 0);
      in_clear = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 24) == 0) in_vs = ~in_vs;
      tick();
    end
    in_we = 0; in_swap = 0; in_clear = 0;
    wait_clear();
    in_vs = 1; tick(); in_vs = 0; tick(); in_vs = 1; tick();

    // Reset in the middle of a clear
    for (int a = 0; a < 121; a++) begin
      in_we = 1; in_addr = 9'(a); in_wdata = 32'h1000 + a; tick();
    end
    in_we = 0;
    b_clr = m_front ? 0 : 1;
    in_clear = 1; tick(); in_clear = 0;
    repeat (100) tick();
    reset_n = 0; #1;
    model_reset();
    chk("t6_rdata", bus.cpu_rdata, 0);
    chk("t6_vdata", bus.vdata, 0);
    chk("t6_front", 32'(bus.front_sel), 0);
    chk("t6_busy", 32'(bus.clear_busy), 0);
    chk("t6_pending", 32'(bus.swap_pending), 0);
    chk("t6_done", 32'(bus.swap_done), 0);
    @(negedge clk); reset_n = 1;
    for (int k = 0; k < 3; k++) begin
      int a;
      a = (k == 0) ? 0 : (k == 1) ? 99 : 100;
      in_addr = 9'(a); in_vaddr = 9'(a); tick();
      exp = (a < 100) ? 32'h0 : 32'h1000 + a;
      if (b_clr == 1) chk($sformatf("t6_word%0d", a), bus.cpu_rdata, exp);
      else            chk($sformatf("t6_word%0d", a), bus.vdata, exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
